pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage MIPS pipeline: PC/IF, ID, EX, ME, WB.
- Generates stage enables, bubbles and flushes so the pipeline runs correctly without forwarding.
- Keeps a 3-entry shadow of in-flight writers (EX, ME, WB) and interlocks ID on RAW hazards.
- Kills younger instructions when a branch or jump resolves taken in ME. Sits beside the CPU top and drives every pipeline register enable.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  input  1  main clock
- arst_n  input  1  asynchronous active-low reset
- enable  input  1  run request; low freezes the whole pipeline
- id_valid  input  1  ID stage holds a real instruction
- id_rs  input  REG_ADDR_W  ID source register 1 (instr[25:21])
- id_rt  input  REG_ADDR_W  ID source register 2 (instr[20:16])
- id_uses_rs  input  1  ID instruction reads rs
- id_uses_rt  input  1  ID instruction reads rt
- id_reg_write  input  1  ID instruction writes the register file
- id_waddr  input  REG_ADDR_W  ID destination (after reg_dst mux)
- me_redirect  input  1  branch taken or jump in ME this cycle
- pc_en  output  1  PC update enable
- if_id_en  output  1  IF/ID register enable
- if_id_flush  output  1  IF/ID loads NOP
- id_ex_bubble  output  1  ID/EX control fields load zero
- ex_me_flush  output  1  EX/ME control fields load zero
- back_en  output  1  ID/EX, EX/ME, ME/WB register enable
- stall  output  1  RAW interlock active this cycle
- stall_left  output  2  cycles until the current hazard clears (0 when none)

Behaviour:
- States: IDLE, RUN, STALL. Reset gives IDLE, all shadow valids 0, and all outputs 0.
- IDLE: all enables and flags 0. Moves to RUN on the first cycle enable=1; outputs follow in that same cycle.
- RUN/STALL: back_en=1. Any state goes to IDLE when enable=0. The shadow freezes and the next entry from IDLE resumes unchanged.
- Shadow entries hold {valid, wr, waddr} for EX, ME and WB.
  - Each cycle with back_en=1: WB<=ME, ME<=EX.
  - EX takes the ID entry, forced invalid if stall or me_redirect.
  - When me_redirect=1, EX is killed: ME takes valid=0 (matches ex_me_flush).
- Register-file writes happen on the clock edge, so ID sees a WB write only the next cycle.
- A matching writer in EX, ME or WB therefore blocks ID.
- Hazard condition: id_valid and, for rs (when id_uses_rs) or rt (when id_uses_rt), src!=0 and some stage has valid and wr and waddr==src.
- stall_left is set by the youngest match: EX=3, ME=2, WB=1.
- Hazard without redirect:
  - pc_en=0, if_id_en=0, id_ex_bubble=1, stall=1; state goes to STALL.
  - Stays in STALL while the hazard persists. stall_left decrements by 1 per cycle.
  - Returns to RUN the cycle the hazard clears.
- me_redirect: has priority over stall.
  - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=1, ex_me_flush=1, stall=0.
  - State goes to RUN. Penalty is 3 cycles. Prediction is not-taken.
- me_redirect while enable=0 is ignored; the ME producer must hold it.
- Normal RUN: pc_en=if_id_en=back_en=1, all flags 0.
- $0 never creates a hazard. id_valid=0 never stalls.
- Reset mid-stall returns to IDLE immediately and clears the shadow.
- Control outputs are combinational from state, shadow and ID/ME inputs. No registered output latency.

Optional Feature:
- Macro: PIPELINE_HAZARD_STATS_EN.
- When defined, adds outputs stall_cycles[CNT_W] and flush_events[CNT_W], plus input stats_clr.
  - stall_cycles increments on every cycle stall=1.
  - flush_events increments on every accepted me_redirect.
  - Both saturate at all-ones, reset to 0, and are cleared synchronously by stats_clr; clear wins over a same-cycle increment.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - state enum {IDLE, RUN, STALL};
  - shadow-entry struct {valid, wr, waddr};
  - constants STALL_EX=3, STALL_ME=2, STALL_WB=1, and REG_ZERO=0.
- One natural sub-module: hazard_scoreboard. It holds the 3-entry shadow shift and produces hazard and stall_left from rs/rt compares.

Test Plan:
- Reset, then enable=1 with independent instructions -> pc_en=if_id_en=back_en=1 every cycle, stall never asserts.
- Writer of $5 in ID, then reader of $5 next cycle -> stall=1 for 3 cycles, stall_left 3,2,1; pc_en=0 and id_ex_bubble=1 on those cycles; resumes on the 4th.
- Reader of $5 two instructions after the writer (one independent in between) -> 2 stall cycles. Reader of $0 after a write to $0 -> 0 stalls.
- me_redirect=1 while a stall on $7 is active -> same cycle: stall=0, pc_en=1, if_id_flush=id_ex_bubble=ex_me_flush=1; next cycle EX and ME shadow entries are invalid.
- enable dropped mid-stall (stall_left=2) -> all enables 0; shadow held. On re-enable, stall resumes with stall_left=2. arst_n pulse mid-stall -> IDLE, all outputs 0.
- With PIPELINE_HAZARD_STATS_EN: 3-cycle stall plus 2 redirects -> stall_cycles=3, flush_events=2. stats_clr -> both 0 the next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The controller and its scoreboard import this package.
package hazard_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [REG_AW-1:0] waddr;
   } shadow_t;

   localparam logic [1:0]        STALL_EX = 2'd3;
   localparam logic [1:0]        STALL_ME = 2'd2;
   localparam logic [1:0]        STALL_WB = 2'd1;
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   // True when an in-flight entry will write register a; $0 never matches.
   function automatic logic writes_reg(shadow_t e, logic [REG_AW-1:0] a);
      return e.valid && e.wr && (e.waddr == a) && (a != REG_ZERO);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// CPU <-> hazard controller bundle. The CPU side is the master; the controller is the slave.
// Optional stats signals exist only with PIPELINE_HAZARD_STATS_EN defined.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  enable;
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rs;
   logic                  id_uses_rt;
   logic                  id_reg_write;
   logic [REG_ADDR_W-1:0] id_waddr;
   logic                  me_redirect;
   logic                  pc_en;
   logic                  if_id_en;
   logic                  if_id_flush;
   logic                  id_ex_bubble;
   logic                  ex_me_flush;
   logic                  back_en;
   logic                  stall;
   logic [1:0]            stall_left;
`ifdef PIPELINE_HAZARD_STATS_EN
   logic                  stats_clr;
   logic [CNT_W-1:0]      stall_cycles;
   logic [CNT_W-1:0]      flush_events;
`endif

   modport master (
      output enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_reg_write, id_waddr, me_redirect,
`ifdef PIPELINE_HAZARD_STATS_EN
      output stats_clr,
      input  stall_cycles, flush_events,
`endif
      input  pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_me_flush,
             back_en, stall, stall_left
   );

   modport slave (
      input  enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_reg_write, id_waddr, me_redirect,
`ifdef PIPELINE_HAZARD_STATS_EN
      input  stats_clr,
      output stall_cycles, flush_events,
`endif
      output pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_me_flush,
             back_en, stall, stall_left
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Three-entry shadow of in-flight writers (EX, ME, WB) and the RAW compare against ID.
// Register-file writes land on the edge, so a WB writer still blocks ID this cycle.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  shift_en,
   input  logic                  kill_ex,
   input  logic                  kill_me,
   input  shadow_t               id_entry,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   output logic                  hazard,
   output logic [1:0]            stall_left
);

   shadow_t ex_q, me_q, wb_q;
   logic [REG_AW-1:0] src_rs, src_rt;
   logic hit_ex, hit_me, hit_wb;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ex_q <= '0;
         me_q <= '0;
         wb_q <= '0;
      end else if (shift_en) begin
         wb_q <= me_q;
         me_q <= kill_me ? '0 : ex_q;
         ex_q <= kill_ex ? '0 : id_entry;
      end
   end

   assign src_rs = REG_AW'(id_rs);
   assign src_rt = REG_AW'(id_rt);

   assign hit_ex = id_valid && ((id_uses_rs && writes_reg(ex_q, src_rs)) ||
                                (id_uses_rt && writes_reg(ex_q, src_rt)));
   assign hit_me = id_valid && ((id_uses_rs && writes_reg(me_q, src_rs)) ||
                                (id_uses_rt && writes_reg(me_q, src_rt)));
   assign hit_wb = id_valid && ((id_uses_rs && writes_reg(wb_q, src_rs)) ||
                                (id_uses_rt && writes_reg(wb_q, src_rt)));

   assign hazard = hit_ex || hit_me || hit_wb;

   // The youngest matching writer sets how long ID must wait.
   always_comb begin
      stall_left = 2'd0;
      if (hit_ex)      stall_left = STALL_EX;
      else if (hit_me) stall_left = STALL_ME;
      else if (hit_wb) stall_left = STALL_WB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage MIPS pipeline sequencer: RAW interlock in ID, redirect flush from ME.
// Optional stall/flush counters with PIPELINE_HAZARD_STATS_EN defined.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   pipeline_hazard_ctrl_if.slave hz
);

   state_t  state;
   logic    active, redirect, hazard, stall_i;
   logic [1:0] sb_left;
   shadow_t id_entry;

   // Outputs are held at zero while reset is asserted, not just after it.
   assign active   = hz.enable && arst_n;
   assign redirect = active && hz.me_redirect;
   assign stall_i  = active && hazard && !hz.me_redirect;

   assign id_entry = '{valid: hz.id_valid, wr: hz.id_reg_write, waddr: REG_AW'(hz.id_waddr)};

   hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
      .clk        (clk),
      .arst_n     (arst_n),
      .shift_en   (active),
      .kill_ex    (stall_i || redirect),
      .kill_me    (redirect),
      .id_entry   (id_entry),
      .id_valid   (hz.id_valid),
      .id_rs      (hz.id_rs),
      .id_rt      (hz.id_rt),
      .id_uses_rs (hz.id_uses_rs),
      .id_uses_rt (hz.id_uses_rt),
      .hazard     (hazard),
      .stall_left (sb_left)
   );

   assign hz.pc_en        = active && !stall_i;
   assign hz.if_id_en     = active && !stall_i;
   assign hz.if_id_flush  = redirect;
   assign hz.id_ex_bubble = redirect || stall_i;
   assign hz.ex_me_flush  = redirect;
   assign hz.back_en      = active;
   assign hz.stall        = stall_i;
   assign hz.stall_left   = stall_i ? sb_left : 2'd0;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
      end else if (!hz.enable) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    state <= stall_i ? STALL : RUN;
            RUN:     if (stall_i)  state <= STALL;
            STALL:   if (!stall_i) state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PIPELINE_HAZARD_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         hz.stall_cycles <= '0;
         hz.flush_events <= '0;
      end else if (hz.stats_clr) begin
         hz.stall_cycles <= '0;
         hz.flush_events <= '0;
      end else begin
         if (stall_i && hz.stall_cycles != CNT_MAX)
            hz.stall_cycles <= hz.stall_cycles + 1'b1;
         if (redirect && hz.flush_events != CNT_MAX)
            hz.flush_events <= hz.flush_events + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; stats checks compile with PIPELINE_HAZARD_STATS_EN.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic arst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hz ();

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .hz     (hz)
   );

   // {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_me_flush, back_en, stall, stall_left}
   logic [8:0] obs;
   assign obs = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_bubble,
                 hz.ex_me_flush, hz.back_en, hz.stall, hz.stall_left};

   localparam logic [8:0] ALL0 = 9'b0000000_00;
   localparam logic [8:0] RUNV = 9'b1100010_00;
   localparam logic [8:0] REDV = 9'b1111110_00;
   localparam logic [6:0] STLV = 7'b0001011;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic [4:0] wa);
      hz.id_valid     = v;
      hz.id_rs        = rs;
      hz.id_rt        = rt;
      hz.id_uses_rs   = urs;
      hz.id_uses_rt   = urt;
      hz.id_reg_write = wr;
      hz.id_waddr     = wa;
   endtask

   task automatic drain();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      hz.enable = 1'b0;
      hz.me_redirect = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      checks++;
      if (obs !== ALL0) begin errors++; $display("FAIL reset_idle got %b exp %b", obs, ALL0); end
      hz.enable = 1'b1;
      #1;
      checks++;
      if (obs !== ALL0) begin errors++; $display("FAIL reset_en_held got %b exp %b", obs, ALL0); end
      hz.enable = 1'b0;
      tick();
      arst_n = 1'b1;
      #1;
      checks++;
      if (obs !== ALL0) begin errors++; $display("FAIL idle_after_reset got %b exp %b", obs, ALL0); end
   endtask

   task automatic test_independent();
      hz.enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_id(1'b1, 5'(10 + i), 5'(20 + i), 1'b1, 1'b1, 1'b1, 5'(1 + i));
         #1;
         checks++;
         if (obs !== RUNV) begin errors++; $display("FAIL indep_%0d got %b exp %b", i, obs, RUNV); end
         tick();
      end
      drain();
   endtask

   task automatic test_raw_ex();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5);
      #1;
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL rawex_writer got %b exp %b", obs, RUNV); end
      tick();
      set_id(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (obs !== {STLV, 2'(3 - k)}) begin
            errors++; $display("FAIL rawex_stall_%0d got %b exp %b", k, obs, {STLV, 2'(3 - k)});
         end
         tick();
      end
      #1;
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL rawex_resume got %b exp %b", obs, RUNV); end
      tick();
      drain();
   endtask

   task automatic test_raw_me();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5);
      tick();
      set_id(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 1'b1, 5'd13);
      #1;
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL rawme_indep got %b exp %b", obs, RUNV); end
      tick();
      set_id(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0);
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (obs !== {STLV, 2'(2 - k)}) begin
            errors++; $display("FAIL rawme_stall_%0d got %b exp %b", k, obs, {STLV, 2'(2 - k)});
         end
         tick();
      end
      #1;
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL rawme_resume got %b exp %b", obs, RUNV); end
      tick();
      drain();
   endtask

   task automatic test_zero_and_invalid();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0);
      #1;
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL zero_reg got %b exp %b", obs, RUNV); end
      tick();
      drain();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5);
      tick();
      set_id(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0);
      #1;
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL invalid_id got %b exp %b", obs, RUNV); end
      tick();
      drain();
   endtask

   task automatic test_redirect();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7);
      tick();
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7);
      #1;
      checks++;
      if (obs !== {STLV, 2'd3}) begin errors++; $display("FAIL redir_pre_stall got %b exp %b", obs, {STLV, 2'd3}); end
      hz.me_redirect = 1'b1;
      #1;
      checks++;
      if (obs !== REDV) begin errors++; $display("FAIL redir_over_stall got %b exp %b", obs, REDV); end
      tick();
      hz.me_redirect = 1'b0;
      set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0);
      #1;
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL redir_me_killed got %b exp %b", obs, RUNV); end
      tick();
      // A writer sitting in ID when the redirect lands must not reach EX.
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8);
      hz.me_redirect = 1'b1;
      #1;
      checks++;
      if (obs !== REDV) begin errors++; $display("FAIL redir_plain got %b exp %b", obs, REDV); end
      tick();
      hz.me_redirect = 1'b0;
      set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      #1;
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL redir_ex_killed got %b exp %b", obs, RUNV); end
      tick();
      drain();
   endtask

   task automatic test_enable_drop();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9);
      tick();
      set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      tick();
      #1;
      checks++;
      if (obs !== {STLV, 2'd2}) begin errors++; $display("FAIL endrop_pre got %b exp %b", obs, {STLV, 2'd2}); end
      hz.enable = 1'b0;
      #1;
      checks++;
      if (obs !== ALL0) begin errors++; $display("FAIL endrop_off got %b exp %b", obs, ALL0); end
      tick();
      tick();
      checks++;
      if (obs !== ALL0) begin errors++; $display("FAIL endrop_held got %b exp %b", obs, ALL0); end
      hz.enable = 1'b1;
      #1;
      checks++;
      if (obs !== {STLV, 2'd2}) begin errors++; $display("FAIL endrop_resume got %b exp %b", obs, {STLV, 2'd2}); end
      tick();
      checks++;
      if (obs !== {STLV, 2'd1}) begin errors++; $display("FAIL endrop_last got %b exp %b", obs, {STLV, 2'd1}); end
      tick();
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL endrop_clear got %b exp %b", obs, RUNV); end
      tick();
      drain();
   endtask

   task automatic test_reset_mid_stall();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6);
      tick();
      set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      tick();
      #1;
      checks++;
      if (obs !== {STLV, 2'd2}) begin errors++; $display("FAIL rstmid_pre got %b exp %b", obs, {STLV, 2'd2}); end
      arst_n = 1'b0;
      #1;
      checks++;
      if (obs !== ALL0) begin errors++; $display("FAIL rstmid_zero got %b exp %b", obs, ALL0); end
      #1;
      arst_n = 1'b1;
      tick();
      checks++;
      if (obs !== RUNV) begin errors++; $display("FAIL rstmid_shadow_clr got %b exp %b", obs, RUNV); end
      tick();
      drain();
   endtask

`ifdef PIPELINE_HAZARD_STATS_EN
   task automatic test_stats();
      hz.stats_clr = 1'b1;
      tick();
      hz.stats_clr = 1'b0;
      checks++;
      if ({hz.stall_cycles, hz.flush_events} !== 32'd0) begin
         errors++; $display("FAIL stats_clr0 got %0d/%0d exp 0/0", hz.stall_cycles, hz.flush_events);
      end
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      repeat (4) tick();
      drain();
      hz.me_redirect = 1'b1;
      tick();
      tick();
      hz.me_redirect = 1'b0;
      checks++;
      if (hz.stall_cycles !== 16'd3) begin errors++; $display("FAIL stats_stall got %0d exp 3", hz.stall_cycles); end
      checks++;
      if (hz.flush_events !== 16'd2) begin errors++; $display("FAIL stats_flush got %0d exp 2", hz.flush_events); end
      hz.stats_clr = 1'b1;
      hz.me_redirect = 1'b1;
      tick();
      hz.stats_clr = 1'b0;
      hz.me_redirect = 1'b0;
      checks++;
      if ({hz.stall_cycles, hz.flush_events} !== 32'd0) begin
         errors++; $display("FAIL stats_clr_wins got %0d/%0d exp 0/0", hz.stall_cycles, hz.flush_events);
      end
   endtask
`endif

   initial begin
`ifdef PIPELINE_HAZARD_STATS_EN
      hz.stats_clr = 1'b0;
`endif
      test_reset();
      test_independent();
      test_raw_ex();
      test_raw_me();
      test_zero_and_invalid();
      test_redirect();
      test_enable_drop();
      test_reset_mid_stall();
`ifdef PIPELINE_HAZARD_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
